banco_registros: RTL and testbench



---
 rtl/banco_registros_pkg.sv | 21 ++
 rtl/banco_registros_dbg_scan.sv | 60 ++++++
 rtl/banco_registros.sv | 54 +++++
 tb/tb_banco_registros.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/banco_registros_pkg.sv
// Shared constants for the integer register file and its debug scanner.
// Instruction field positions let the decoder and the file agree on operand slicing.
package banco_registros_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int DIV_W      = 8;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  function automatic reg_addr_t field_at(input logic [XLEN-1:0] instr, input int lsb);
    return instr[lsb +: REG_ADDR_W];
  endfunction

endpackage

// File: rtl/banco_registros_dbg_scan.sv
// Debug index (manual select or timed auto-scan) plus the registered
// address/data pair that drives the 7-segment displays.
module banco_registros_dbg_scan
  import banco_registros_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int W        = 32,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk_w,
  input  logic                  rst_ni,
  input  logic                  scan_en_i,
  input  logic [REG_ADDR_W-1:0] dbg_sel_i,
  input  logic [W-1:0]          regs_i [NREG],
  output logic [REG_ADDR_W-1:0] dbg_addr_o,
  output logic [W-1:0]          dbg_data_o
);

  if (SCAN_DIV < 1 || SCAN_DIV > 255) begin : g_bad_scan_div
    $error("SCAN_DIV must lie in 1..255");
  end

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [REG_ADDR_W-1:0] IDX_LAST = REG_ADDR_W'(NREG - 1);

  logic [DIV_W-1:0]      div_p0;
  logic [REG_ADDR_W-1:0] idx_p0;

  function automatic logic [REG_ADDR_W-1:0] next_idx(input logic [REG_ADDR_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  // Stage p0: scan divider and displayed-register index
  always_ff @(posedge clk_w or negedge rst_ni) begin
    if (!rst_ni) begin
      div_p0 <= '0;
      idx_p0 <= '0;
    end else if (!scan_en_i) begin
      div_p0 <= '0;
      idx_p0 <= dbg_sel_i;
    end else if (div_p0 == DIV_LAST) begin
      div_p0 <= '0;
      idx_p0 <= next_idx(idx_p0);
    end else begin
      div_p0 <= div_p0 + 1'b1;
    end
  end

  // Stage p1: address and contents captured together so the pair never tears
  always_ff @(posedge clk_w or negedge rst_ni) begin
    if (!rst_ni) begin
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
    end else begin
      dbg_addr_o <= idx_p0;
      dbg_data_o <= regs_i[idx_p0];
    end
  end

endmodule

// File: rtl/banco_registros.sv
// 32x32 integer register file: two combinational read ports, one write port,
// and a registered debug view of the contents.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int W        = 32,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk_w,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  regwrite_i,
  input  logic [W-1:0]          wdata_i,
  output logic [W-1:0]          rs1_data_o,
  output logic [W-1:0]          rs2_data_o,
  input  logic                  scan_en_i,
  input  logic [REG_ADDR_W-1:0] dbg_sel_i,
  output logic [REG_ADDR_W-1:0] dbg_addr_o,
  output logic [W-1:0]          dbg_data_o
);

  logic [W-1:0] regs [NREG];

  // Write port: x0 is never written, so its reset value of 0 is permanent
  always_ff @(posedge clk_w or negedge rst_ni) begin
    if (!rst_ni) begin
      regs <= '{default: '0};
    end else if (regwrite_i && (rd_i != ZERO_REG)) begin
      regs[rd_i] <= wdata_i;
    end
  end

  // No write bypass: forwarding wdata here would close a loop through the ALU
  assign rs1_data_o = (rs1_i == ZERO_REG) ? '0 : regs[rs1_i];
  assign rs2_data_o = (rs2_i == ZERO_REG) ? '0 : regs[rs2_i];

  banco_registros_dbg_scan #(
    .NREG     (NREG),
    .W        (W),
    .SCAN_DIV (SCAN_DIV)
  ) u_dbg_scan (
    .clk_w      (clk_w),
    .rst_ni     (rst_ni),
    .scan_en_i  (scan_en_i),
    .dbg_sel_i  (dbg_sel_i),
    .regs_i     (regs),
    .dbg_addr_o (dbg_addr_o),
    .dbg_data_o (dbg_data_o)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Directed bench for banco_registros with hand-computed expectations.
module tb_banco_registros;

  logic        clk_w = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        regwrite_i;
  logic [31:0] wdata_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        scan_en_i;
  logic [4:0]  dbg_sel_i;
  logic [4:0]  dbg_addr_o;
  logic [31:0] dbg_data_o;

  int n_chk = 0;
  int n_err = 0;

  banco_registros #(.NREG(32), .W(32), .SCAN_DIV(4)) dut (
    .clk_w      (clk_w),
    .rst_ni     (rst_ni),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rd_i       (rd_i),
    .regwrite_i (regwrite_i),
    .wdata_i    (wdata_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .scan_en_i  (scan_en_i),
    .dbg_sel_i  (dbg_sel_i),
    .dbg_addr_o (dbg_addr_o),
    .dbg_data_o (dbg_data_o)
  );

  always #5 clk_w = ~clk_w;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rd_i = a; wdata_i = d; regwrite_i = 1'b1;
    tick();
    regwrite_i = 1'b0;
  endtask

  logic [4:0]  scan_addr [4];
  logic [31:0] scan_data [4];

  initial begin
    rst_ni = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = '0; regwrite_i = 1'b0;
    wdata_i = '0; scan_en_i = 1'b0; dbg_sel_i = '0;
    #23;
    rst_ni = 1'b1;
    #4;

    // Reset state on every address of both ports
    for (int i = 0; i < 32; i++) begin
      rs1_i = 5'(i); rs2_i = 5'(31 - i);
      #1;
      check($sformatf("rst_rs1[%0d]", i), rs1_data_o, 32'h0);
      check($sformatf("rst_rs2[%0d]", 31 - i), rs2_data_o, 32'h0);
    end
    check("rst_dbg_addr", {27'b0, dbg_addr_o}, 32'd0);
    check("rst_dbg_data", dbg_data_o, 32'h0);

    // Read during write: old value before the edge, new one after
    tick();
    rs1_i = 5'd5; rd_i = 5'd5; wdata_i = 32'hDEADBEEF; regwrite_i = 1'b1;
    #1;
    check("rdw_before", rs1_data_o, 32'h0);
    tick();
    regwrite_i = 1'b0;
    check("rdw_after", rs1_data_o, 32'hDEADBEEF);

    // x0 discards writes; regwrite=0 discards writes
    wr(5'd0, 32'h12345678);
    rs2_i = 5'd0; #1;
    check("x0_stays_zero", rs2_data_o, 32'h0);
    rd_i = 5'd3; wdata_i = 32'hCAFEF00D; regwrite_i = 1'b0;
    tick();
    rs1_i = 5'd3; #1;
    check("no_we_x3", rs1_data_o, 32'h0);
    rs2_i = 5'd5; #1;
    check("rs2_x5", rs2_data_o, 32'hDEADBEEF);

    // Manual debug select: index loads at one edge, outputs at the next
    dbg_sel_i = 5'd5;
    tick();
    tick();
    check("man_addr", {27'b0, dbg_addr_o}, 32'd5);
    check("man_data", dbg_data_o, 32'hDEADBEEF);
    rd_i = 5'd5; wdata_i = 32'h1; regwrite_i = 1'b1;
    tick();
    regwrite_i = 1'b0;
    check("man_data_write_edge", dbg_data_o, 32'hDEADBEEF);
    tick();
    check("man_data_after_write", dbg_data_o, 32'h1);

    // Auto-scan 30,31,0,1 each held 4 edges
    wr(5'd31, 32'hA5A50031);
    wr(5'd1, 32'h00000011);
    dbg_sel_i = 5'd30;
    tick();
    tick();
    check("scan_start_addr", {27'b0, dbg_addr_o}, 32'd30);
    scan_addr[0] = 5'd30; scan_data[0] = 32'h0;
    scan_addr[1] = 5'd31; scan_data[1] = 32'hA5A50031;
    scan_addr[2] = 5'd0;  scan_data[2] = 32'h0;
    scan_addr[3] = 5'd1;  scan_data[3] = 32'h00000011;
    scan_en_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("scan_addr_e%0d", k), {27'b0, dbg_addr_o}, {27'b0, scan_addr[(k-1)/4]});
      check($sformatf("scan_data_e%0d", k), dbg_data_o, scan_data[(k-1)/4]);
    end

    // Leave scan: idx takes dbg_sel, visible two edges later
    scan_en_i = 1'b0; dbg_sel_i = 5'd7;
    tick();
    check("stop_addr_e1", {27'b0, dbg_addr_o}, 32'd2);
    tick();
    check("stop_addr_e2", {27'b0, dbg_addr_o}, 32'd7);

    // Divider must restart from 0 after a short pause mid-count
    scan_en_i = 1'b1;
    tick();
    tick();
    scan_en_i = 1'b0;
    tick();
    scan_en_i = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check("resume_addr_e4", {27'b0, dbg_addr_o}, 32'd7);
    tick();
    check("resume_addr_e5", {27'b0, dbg_addr_o}, 32'd8);

    // Asynchronous reset mid-scan, between edges
    scan_en_i = 1'b0; dbg_sel_i = 5'd5;
    tick();
    tick();
    check("pre_rst_data", dbg_data_o, 32'h1);
    scan_en_i = 1'b1;
    tick();
    #2;
    rst_ni = 1'b0;
    rs1_i = 5'd5; rs2_i = 5'd31;
    #1;
    check("async_rst_rs1", rs1_data_o, 32'h0);
    check("async_rst_rs2", rs2_data_o, 32'h0);
    check("async_rst_addr", {27'b0, dbg_addr_o}, 32'd0);
    check("async_rst_data", dbg_data_o, 32'h0);
    @(negedge clk_w);
    rst_ni = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check("post_rst_addr_e4", {27'b0, dbg_addr_o}, 32'd0);
    tick();
    check("post_rst_addr_e5", {27'b0, dbg_addr_o}, 32'd1);
    check("post_rst_data_x1", dbg_data_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
